// File: rtl/sec32_encoder.sv
// Two-stage pipelined SEC encoder: 32 data bits in, 40-bit codeword (data + 8 check bits) out.
// Optional error injection on the S2 load path when SEC32_ENC_ERRINJ_EN is defined.
module sec32_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [7:0]  out_check,
    output logic [15:0] out_count
`ifdef SEC32_ENC_ERRINJ_EN
    ,
    input  logic        inj_valid,
    input  logic [5:0]  inj_pos
`endif
);

    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 8;
    localparam int unsigned NW   = 8;
    localparam int unsigned PW   = DW + CW;
    localparam int unsigned CNTW = 16;

    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_data_q,  s1_data_d;
    logic [NW-1:0] s1_nib_q,   s1_nib_d;
    logic [CW-1:0] s1_col_q,   s1_col_d;

    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_data_q,  s2_data_d;
    logic [CW-1:0] s2_check_q, s2_check_d;

    logic [CNTW-1:0] count_q, count_d;

    logic          s1_ready;
    logic          s2_ready;
    logic [CW-1:0] check_c;
    logic [PW-1:0] flip_c;
    logic [PW-1:0] codeword_c;

    // Check bits from nibble parities and column parities held in S1
    always_comb begin
        check_c    = '0;
        check_c[0] = s1_nib_q[4] ^ s1_nib_q[5] ^ s1_col_q[0];
        check_c[1] = s1_nib_q[6] ^ s1_nib_q[7] ^ s1_col_q[1];
        check_c[2] = s1_nib_q[4] ^ s1_nib_q[6] ^ s1_col_q[2];
        check_c[3] = s1_nib_q[5] ^ s1_nib_q[7] ^ s1_col_q[3];
        check_c[4] = s1_nib_q[0] ^ s1_nib_q[1] ^ s1_col_q[4];
        check_c[5] = s1_nib_q[2] ^ s1_nib_q[3] ^ s1_col_q[5];
        check_c[6] = s1_nib_q[0] ^ s1_nib_q[2] ^ s1_col_q[6];
        check_c[7] = s1_nib_q[1] ^ s1_nib_q[3] ^ s1_col_q[7];
    end

    // Single-bit inversion mask applied as S2 loads a word
    always_comb begin
        flip_c = '0;
`ifdef SEC32_ENC_ERRINJ_EN
        if (inj_valid && (inj_pos < 6'd40)) begin
            flip_c = PW'(1) << inj_pos;
        end
`endif
        codeword_c = {check_c, s1_data_q} ^ flip_c;
    end

    // Handshake, stage loads and output counter
    always_comb begin
        s2_ready   = !s2_valid_q || out_ready;
        s1_ready   = !s1_valid_q || s2_ready;
        in_ready   = s1_ready;

        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_nib_d   = s1_nib_q;
        s1_col_d   = s1_col_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_check_d = s2_check_q;
        count_d    = count_q;

        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                for (int k = 0; k < 8; k++) begin
                    s1_nib_d[k] = ^in_data[4*k +: 4];
                end
                for (int r = 0; r < 4; r++) begin
                    s1_col_d[r]   = in_data[r]    ^ in_data[r+4]  ^ in_data[r+8]  ^ in_data[r+12];
                    s1_col_d[4+r] = in_data[16+r] ^ in_data[20+r] ^ in_data[24+r] ^ in_data[28+r];
                end
            end
        end

        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d  = codeword_c[DW-1:0];
                s2_check_d = codeword_c[PW-1:DW];
            end
        end

        if (s2_valid_q && out_ready) begin
            count_d = count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_nib_q   <= '0;
            s1_col_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_check_q <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_nib_q   <= s1_nib_d;
            s1_col_q   <= s1_col_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_check_q <= s2_check_d;
            count_q    <= count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_check = s2_check_q;
    assign out_count = count_q;

endmodule
